// File: rtl/power_pkg.sv
// Shared types and defaults for the rail power sequencer.
package power_pkg;

  typedef enum logic [2:0] {
    IDLE,
    UP,
    DWELL,
    READY,
    DOWN,
    FAULT
  } pseq_state_t;

  localparam int PSEQ_STEP_DLY   = 10;
  localparam int PSEQ_PG_TIMEOUT = 200;
  localparam int CLK_PERIOD_NS   = 10;

  function automatic int pseq_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/power_seq_if.sv
// Sequencer request/status bundle: enable, power-good and fault acknowledge in; rail enables and status out.
interface power_seq_if #(
  parameter int N_RAILS = 4
);
  logic                       enable;
  logic [N_RAILS-1:0]         rail_pg;
  logic                       fault_clr;
  logic [N_RAILS-1:0]         rail_en;
  logic                       sys_ready;
  logic                       fault;
  logic [$clog2(N_RAILS)-1:0] fault_rail;

  modport master (
    output enable, rail_pg, fault_clr,
    input  rail_en, sys_ready, fault, fault_rail
  );

  modport slave (
    input  enable, rail_pg, fault_clr,
    output rail_en, sys_ready, fault, fault_rail
  );
endinterface

// File: rtl/pseq_timer.sv
// Clearable saturating up-counter with an equality compare; o_eq is combinational on the count.
// Clear takes effect on the next edge; the count holds at all-ones instead of wrapping.
module pseq_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         resetb,
  input  logic         i_clr,
  input  logic [W-1:0] i_cmp,
  output logic         o_eq
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (r_cnt != '1) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_eq = (r_cnt == i_cmp);

endmodule

// File: rtl/power_seq.sv
// Multi-rail power sequencer: ordered bring-up with power-good timeout, reverse power-down, latched fault.
// All outputs registered, one-cycle latency from sampled inputs; no backpressure, inputs are levels.
module power_seq
  import power_pkg::*;
#(
  parameter int N_RAILS    = 4,
  parameter int STEP_DLY   = PSEQ_STEP_DLY,
  parameter int PG_TIMEOUT = PSEQ_PG_TIMEOUT
) (
  input  logic       clk,
  input  logic       resetb,
  power_seq_if.slave bus
);

  localparam int IW = $clog2(N_RAILS);
  localparam int TW = $clog2(pseq_max(STEP_DLY, PG_TIMEOUT) + 1);
  // Compare values are one less than the delays because the count is 0 on the first cycle in a state.
  localparam logic [TW-1:0] STEP_CMP = TW'(STEP_DLY - 1);
  localparam logic [TW-1:0] TO_CMP   = TW'(PG_TIMEOUT - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_RAILS - 1);

  pseq_state_t        r_state;
  logic [IW-1:0]      r_idx;
  logic [N_RAILS-1:0] r_rail_en;
  logic               r_sys_ready;
  logic               r_fault;
  logic [IW-1:0]      r_fault_rail;

  pseq_state_t        w_state_nxt;
  logic [IW-1:0]      w_idx_nxt;
  logic [N_RAILS-1:0] w_rail_en_nxt;
  logic               w_sys_ready_nxt;
  logic               w_fault_nxt;
  logic [IW-1:0]      w_fault_rail_nxt;

  logic [N_RAILS-1:0] w_mon;
  logic [N_RAILS-1:0] w_fail;
  logic [IW-1:0]      w_fail_idx;
  logic               w_flt;
  logic [IW-1:0]      w_flt_rail;
  logic               w_go_down;
  logic               w_tmr_clr;
  logic [TW-1:0]      w_tmr_cmp;
  logic               w_tmr_eq;

  pseq_timer #(
    .W (TW)
  ) u_timer (
    .clk    (clk),
    .resetb (resetb),
    .i_clr  (w_tmr_clr),
    .i_cmp  (w_tmr_cmp),
    .o_eq   (w_tmr_eq)
  );

  // Rails already brought up are watched; the rail being raised joins once its power-good is seen.
  always_comb begin
    w_mon = '0;
    for (int i = 0; i < N_RAILS; i++) begin
      case (r_state)
        UP:      w_mon[i] = (i < int'(r_idx));
        DWELL:   w_mon[i] = (i <= int'(r_idx));
        READY:   w_mon[i] = 1'b1;
        default: w_mon[i] = 1'b0;
      endcase
    end
  end

  always_comb begin
    w_fail     = w_mon & ~bus.rail_pg;
    w_fail_idx = '0;
    for (int i = N_RAILS - 1; i >= 0; i--) begin
      if (w_fail[i]) w_fail_idx = IW'(i);
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_idx_nxt        = r_idx;
    w_rail_en_nxt    = r_rail_en;
    w_sys_ready_nxt  = r_sys_ready;
    w_fault_nxt      = r_fault;
    w_fault_rail_nxt = r_fault_rail;
    w_tmr_clr        = 1'b0;
    w_tmr_cmp        = STEP_CMP;
    w_flt            = 1'b0;
    w_flt_rail       = w_fail_idx;
    w_go_down        = 1'b0;

    case (r_state)
      IDLE: begin
        if (bus.enable) begin
          w_state_nxt      = UP;
          w_idx_nxt        = '0;
          w_rail_en_nxt    = '0;
          w_rail_en_nxt[0] = 1'b1;
        end
      end
      UP: begin
        w_tmr_cmp = TO_CMP;
        if (|w_fail) begin
          w_flt = 1'b1;
        end else if (!bus.rail_pg[r_idx] && w_tmr_eq) begin
          w_flt      = 1'b1;
          w_flt_rail = r_idx;
        end else if (!bus.enable) begin
          w_go_down = 1'b1;
        end else if (bus.rail_pg[r_idx]) begin
          w_state_nxt = DWELL;
        end
      end
      DWELL: begin
        if (|w_fail) begin
          w_flt = 1'b1;
        end else if (!bus.enable) begin
          w_go_down = 1'b1;
        end else if (w_tmr_eq) begin
          if (r_idx == LAST_IDX) begin
            w_state_nxt     = READY;
            w_sys_ready_nxt = 1'b1;
          end else begin
            w_state_nxt                   = UP;
            w_idx_nxt                     = r_idx + 1'b1;
            w_rail_en_nxt[r_idx + 1'b1]   = 1'b1;
          end
        end
      end
      READY: begin
        if (|w_fail) begin
          w_flt = 1'b1;
        end else if (!bus.enable) begin
          w_go_down = 1'b1;
        end
      end
      DOWN: begin
        if (w_tmr_eq) begin
          w_tmr_clr = 1'b1;
          if (r_idx == '0) begin
            w_state_nxt = IDLE;
          end else begin
            w_idx_nxt                   = r_idx - 1'b1;
            w_rail_en_nxt[r_idx - 1'b1] = 1'b0;
          end
        end
      end
      FAULT: begin
        if (bus.fault_clr && !bus.enable) begin
          w_state_nxt      = IDLE;
          w_idx_nxt        = '0;
          w_fault_nxt      = 1'b0;
          w_fault_rail_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    if (w_go_down) begin
      w_state_nxt          = DOWN;
      w_rail_en_nxt[r_idx] = 1'b0;
      w_sys_ready_nxt      = 1'b0;
    end

    if (w_flt) begin
      w_state_nxt      = FAULT;
      w_rail_en_nxt    = '0;
      w_sys_ready_nxt  = 1'b0;
      w_fault_nxt      = 1'b1;
      w_fault_rail_nxt = w_flt_rail;
    end

    if (w_state_nxt != r_state) w_tmr_clr = 1'b1;
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_state      <= IDLE;
      r_idx        <= '0;
      r_rail_en    <= '0;
      r_sys_ready  <= 1'b0;
      r_fault      <= 1'b0;
      r_fault_rail <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_idx        <= w_idx_nxt;
      r_rail_en    <= w_rail_en_nxt;
      r_sys_ready  <= w_sys_ready_nxt;
      r_fault      <= w_fault_nxt;
      r_fault_rail <= w_fault_rail_nxt;
    end
  end

  assign bus.rail_en    = r_rail_en;
  assign bus.sys_ready  = r_sys_ready;
  assign bus.fault      = r_fault;
  assign bus.fault_rail = r_fault_rail;

endmodule

// File: tb/tb_power_seq.sv
// Directed bench for power_seq: bring-up, power-down, timeout, power-good loss, same-cycle priorities, async reset.
module tb_power_seq;
  import power_pkg::*;

  logic clk = 1'b0;
  logic resetb = 1'b1;

  always #(CLK_PERIOD_NS / 2) clk = ~clk;

  power_seq_if #(.N_RAILS(4)) bus ();

  power_seq #(
    .N_RAILS    (4),
    .STEP_DLY   (10),
    .PG_TIMEOUT (200)
  ) dut (
    .clk    (clk),
    .resetb (resetb),
    .bus    (bus.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [3:0] pg_auto;
  logic [3:0] pg_drop;
  int         pg_delay [4];
  int         pg_cnt   [4];

  // Board model: rail_pg[k] is first sampled high pg_delay[k] edges after rail_en[k] rose.
  always @(posedge clk) begin
    #2;
    for (int k = 0; k < 4; k++) begin
      if (!bus.rail_en[k]) pg_cnt[k] = 0;
      else if (pg_cnt[k] < 1000) pg_cnt[k]++;
      bus.rail_pg[k] = pg_auto[k] && !pg_drop[k] && (pg_cnt[k] >= pg_delay[k]);
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic run_timeout(input bit drop_en);
    int         ft;
    logic [3:0] en_pre;
    ft          = -1;
    en_pre      = '0;
    pg_auto     = 4'b1011;
    bus.enable  = 1'b1;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (t == 229) begin
        en_pre = bus.rail_en;
        if (drop_en) bus.enable = 1'b0;
      end
      if (bus.fault && ft < 0) ft = t;
    end
    check(drop_en ? "to_drop_fault_cycle" : "timeout_fault_cycle", ft, 230);
    check(drop_en ? "to_drop_en_before" : "timeout_en_before", 32'(en_pre), 7);
    check(drop_en ? "to_drop_en_after" : "timeout_en_after", 32'(bus.rail_en), 0);
    check(drop_en ? "to_drop_fault_rail" : "timeout_fault_rail", 32'(bus.fault_rail), 2);
    check(drop_en ? "to_drop_ready" : "timeout_ready", 32'(bus.sys_ready), 0);
    bus.fault_clr = 1'b1;
    if (!drop_en) begin
      repeat (3) @(negedge clk);
      check("clr_with_enable_fault", 32'(bus.fault), 1);
      check("clr_with_enable_rail", 32'(bus.fault_rail), 2);
      bus.enable = 1'b0;
    end
    @(negedge clk);
    check(drop_en ? "to_drop_clr_fault" : "timeout_clr_fault", 32'(bus.fault), 0);
    check(drop_en ? "to_drop_clr_rail" : "timeout_clr_rail", 32'(bus.fault_rail), 0);
    bus.fault_clr = 1'b0;
    pg_auto       = 4'b1111;
    @(negedge clk);
  endtask

  initial begin
    int  rise [4];
    int  fall [4];
    int  rdy_t;
    int  rerise;
    bit  seen;
    logic [3:0] en230;
    int  f230;

    bus.enable    = 1'b0;
    bus.fault_clr = 1'b0;
    pg_auto       = 4'b1111;
    pg_drop       = 4'b0000;
    for (int k = 0; k < 4; k++) pg_delay[k] = 5;
    #1 resetb = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_rail_en", 32'(bus.rail_en), 0);
    check("rst_sys_ready", 32'(bus.sys_ready), 0);
    check("rst_fault", 32'(bus.fault), 0);
    check("rst_fault_rail", 32'(bus.fault_rail), 0);
    resetb = 1'b1;
    repeat (2) @(negedge clk);

    // Bring-up: rails at E, E+15, E+30, E+45, ready at E+60
    for (int k = 0; k < 4; k++) rise[k] = -1;
    rdy_t      = -1;
    bus.enable = 1'b1;
    for (int t = 0; t < 80; t++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) if (bus.rail_en[k] && rise[k] < 0) rise[k] = t;
      if (bus.sys_ready && rdy_t < 0) rdy_t = t;
    end
    check("up_rise0", rise[0], 0);
    check("up_rise1", rise[1], 15);
    check("up_rise2", rise[2], 30);
    check("up_rise3", rise[3], 45);
    check("up_ready", rdy_t, 60);

    // Power-down from READY with an ignored enable pulse, then restart once IDLE
    for (int k = 0; k < 4; k++) fall[k] = -1;
    rerise     = -1;
    bus.enable = 1'b0;
    for (int t = 0; t < 46; t++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) if (!bus.rail_en[k] && fall[k] < 0) fall[k] = t;
      if (t > 30 && bus.rail_en[0] && rerise < 0) rerise = t;
      if (t == 4)  bus.enable = 1'b1;
      if (t == 5)  bus.enable = 1'b0;
      if (t == 35) bus.enable = 1'b1;
    end
    check("down_fall3", fall[3], 0);
    check("down_fall2", fall[2], 10);
    check("down_fall1", fall[1], 20);
    check("down_fall0", fall[0], 30);
    check("down_restart", rerise, 41);

    for (int i = 0; i < 100 && !bus.sys_ready; i++) @(negedge clk);
    check("restart_ready", 32'(bus.sys_ready), 1);

    // Single-cycle power-good loss on rail 1 in READY
    pg_drop = 4'b0010;
    seen    = 1'b0;
    for (int i = 0; i < 4 && !seen; i++) begin
      @(negedge clk);
      if (!bus.rail_pg[1]) seen = 1'b1;
    end
    check("pgloss_seen", 32'(seen), 1);
    check("pgloss_no_early_fault", 32'(bus.fault), 0);
    @(negedge clk);
    pg_drop = 4'b0000;
    check("pgloss_rail_en", 32'(bus.rail_en), 0);
    check("pgloss_fault", 32'(bus.fault), 1);
    check("pgloss_fault_rail", 32'(bus.fault_rail), 1);
    check("pgloss_ready", 32'(bus.sys_ready), 0);
    bus.enable    = 1'b0;
    bus.fault_clr = 1'b1;
    @(negedge clk);
    check("pgloss_clr", 32'(bus.fault), 0);
    bus.fault_clr = 1'b0;
    @(negedge clk);

    run_timeout(1'b0);
    run_timeout(1'b1);

    // Rail 2 power-good lands exactly on the timeout edge
    pg_delay[2] = 200;
    rise[3]     = -1;
    en230       = '0;
    f230        = -1;
    bus.enable  = 1'b1;
    for (int t = 0; t <= 246; t++) begin
      @(negedge clk);
      if (t == 230) begin
        en230 = bus.rail_en;
        f230  = int'(bus.fault);
      end
      if (bus.rail_en[3] && rise[3] < 0) rise[3] = t;
    end
    check("pg_on_to_fault", f230, 0);
    check("pg_on_to_rail_en", 32'(en230), 7);
    check("pg_on_to_next_rise", rise[3], 240);
    check("pg_on_to_mid_dwell", 32'(bus.rail_en), 15);

    // Asynchronous reset mid-DWELL, away from any clock edge
    #2 resetb = 1'b0;
    #1;
    check("arst_rail_en", 32'(bus.rail_en), 0);
    check("arst_ready", 32'(bus.sys_ready), 0);
    check("arst_fault", 32'(bus.fault), 0);
    @(negedge clk);
    pg_delay[2] = 5;
    resetb      = 1'b1;
    for (int t = 0; t < 16; t++) begin
      @(negedge clk);
      if (t == 0)  check("arst_restart_r0", 32'(bus.rail_en), 1);
      if (t == 14) check("arst_restart_hold", 32'(bus.rail_en), 1);
      if (t == 15) check("arst_restart_r1", 32'(bus.rail_en), 3);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
